// File: rtl/dino_game_controller.sv
//==============================================================================
// Module   : dino_game_controller
// Purpose  : Top-level game sequencer for the dino runner. Runs the
//            IDLE / RUNNING / GAME_OVER state machine, samples the collision
//            flag once per video frame, and keeps score, high score and
//            scroll speed for the obstacle mover.
// Ports    : clk        - system clock
//            rst_n      - asynchronous active-low reset
//            frame_tick - one-cycle pulse per video frame
//            jump_btn   - synchronised, debounced button level
//            collision  - combinational hit flag from collision detector
//            state      - 00 IDLE, 01 RUNNING, 10 GAME_OVER
//            run_en     - high while RUNNING (scroller / physics enable)
//            obj_clear  - one-cycle pulse at the first RUNNING cycle
//            score      - current score (binary, saturating)
//            hi_score   - best score since reset
//            speed      - scroll speed in pixels/frame
//            game_over  - high while in GAME_OVER
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module dino_game_controller #(
    parameter int SCORE_DIV   = 6,
    parameter int SCORE_MAX   = 9999,
    parameter int SPEED_INIT  = 4,
    parameter int SPEED_MAX   = 12,
    parameter int SPEED_STEP  = 100,
    parameter int HOLD_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        jump_btn,
    input  logic        collision,
    output logic [1:0]  state,
    output logic        run_en,
    output logic        obj_clear,
    output logic [13:0] score,
    output logic [13:0] hi_score,
    output logic [3:0]  speed,
    output logic        game_over
);

    localparam int DIV_W  = (SCORE_DIV  > 1) ? $clog2(SCORE_DIV)  : 1;
    localparam int STEP_W = (SPEED_STEP > 1) ? $clog2(SPEED_STEP) : 1;
    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(SCORE_DIV - 1);
    localparam logic [STEP_W-1:0] STEP_LAST   = STEP_W'(SPEED_STEP - 1);
    localparam logic [HOLD_W-1:0] HOLD_DONE   = HOLD_W'(HOLD_FRAMES);
    localparam logic [13:0]       SCORE_TOP   = 14'(SCORE_MAX);
    localparam logic [3:0]        SPEED_START = 4'(SPEED_INIT);
    localparam logic [3:0]        SPEED_TOP   = 4'(SPEED_MAX);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_RUNNING   = 2'b01,
        ST_GAME_OVER = 2'b10
    } state_t;

    state_t              cur_state;
    state_t              nxt_state;
    logic                btn_q;
    logic                btn_rise;
    logic                start_run;
    logic                hit;
    logic [DIV_W-1:0]    div_cnt;
    logic [STEP_W-1:0]   step_cnt;
    logic [HOLD_W-1:0]   hold_cnt;

    // Only a fresh press counts; a held level never retriggers a run.
    assign btn_rise = jump_btn & ~btn_q;
    assign state    = cur_state;

    //--------------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= ST_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    //--------------------------------------------------------------------------
    // Next-state logic. start_run marks the edge that begins a run (from
    // IDLE or after the GAME_OVER hold-off); hit marks a frame-sampled
    // collision, which takes priority over any score update on that tick.
    //--------------------------------------------------------------------------
    always_comb begin
        nxt_state = cur_state;
        start_run = 1'b0;
        hit       = 1'b0;
        case (cur_state)
            ST_IDLE: begin
                if (btn_rise) begin
                    nxt_state = ST_RUNNING;
                    start_run = 1'b1;
                end
            end
            ST_RUNNING: begin
                if (frame_tick && collision) begin
                    nxt_state = ST_GAME_OVER;
                    hit       = 1'b1;
                end
            end
            ST_GAME_OVER: begin
                if (btn_rise && (hold_cnt == HOLD_DONE)) begin
                    nxt_state = ST_RUNNING;
                    start_run = 1'b1;
                end
            end
            default: begin
                // Encoding 11 is unreachable; fall back to IDLE.
                nxt_state = ST_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Registered outputs and game counters
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q     <= 1'b0;
            run_en    <= 1'b0;
            obj_clear <= 1'b0;
            game_over <= 1'b0;
            score     <= '0;
            hi_score  <= '0;
            speed     <= SPEED_START;
            div_cnt   <= '0;
            step_cnt  <= '0;
            hold_cnt  <= '0;
        end else begin
            btn_q     <= jump_btn;
            // Output flags follow the next state so they change on the same
            // edge as the state register.
            obj_clear <= start_run;
            run_en    <= (nxt_state == ST_RUNNING);
            game_over <= (nxt_state == ST_GAME_OVER);

            if (start_run) begin
                score    <= '0;
                speed    <= SPEED_START;
                div_cnt  <= '0;
                step_cnt <= '0;
            end else if (hit) begin
                hold_cnt <= '0;
                if (score > hi_score) begin
                    hi_score <= score;
                end
            end else if ((cur_state == ST_RUNNING) && frame_tick) begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt <= '0;
                    // At the score ceiling the step counter freezes too.
                    if (score < SCORE_TOP) begin
                        score <= score + 14'd1;
                        if (step_cnt == STEP_LAST) begin
                            step_cnt <= '0;
                            if (speed < SPEED_TOP) begin
                                speed <= speed + 4'd1;
                            end
                        end else begin
                            step_cnt <= step_cnt + 1'b1;
                        end
                    end
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end else if ((cur_state == ST_GAME_OVER) && frame_tick &&
                         (hold_cnt != HOLD_DONE)) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dino_game_controller.sv
//==============================================================================
// Module   : tb_dino_game_controller
// Purpose  : Self-checking bench for dino_game_controller. A table of
//            vectors, hand sequences for the multi-cycle corners, and a
//            randomized phase, all checked against a tick-counting model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_dino_game_controller;

    localparam int SCORE_DIV   = 6;
    localparam int SCORE_MAX   = 9999;
    localparam int SPEED_INIT  = 4;
    localparam int SPEED_MAX   = 12;
    localparam int SPEED_STEP  = 100;
    localparam int HOLD_FRAMES = 30;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_tick;
    logic        jump_btn;
    logic        collision;
    logic [1:0]  state;
    logic        run_en;
    logic        obj_clear;
    logic [13:0] score;
    logic [13:0] hi_score;
    logic [3:0]  speed;
    logic        game_over;

    dino_game_controller #(
        .SCORE_DIV  (SCORE_DIV),
        .SCORE_MAX  (SCORE_MAX),
        .SPEED_INIT (SPEED_INIT),
        .SPEED_MAX  (SPEED_MAX),
        .SPEED_STEP (SPEED_STEP),
        .HOLD_FRAMES(HOLD_FRAMES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .frame_tick(frame_tick),
        .jump_btn  (jump_btn),
        .collision (collision),
        .state     (state),
        .run_en    (run_en),
        .obj_clear (obj_clear),
        .score     (score),
        .hi_score  (hi_score),
        .speed     (speed),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0 idle, 1 running, 2 game over. Score and speed
    // are derived from the number of clean frame ticks seen in this run.
    int m_mode;
    int m_ticks;
    int m_hi;
    int m_hold;
    int m_btnq;
    int m_clear;

    function automatic int m_score();
        int s;
        s = m_ticks / SCORE_DIV;
        return (s > SCORE_MAX) ? SCORE_MAX : s;
    endfunction

    function automatic int m_speed();
        int v;
        v = SPEED_INIT + m_score() / SPEED_STEP;
        return (v > SPEED_MAX) ? SPEED_MAX : v;
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_ticks = 0;
        m_hi    = 0;
        m_hold  = 0;
        m_btnq  = 0;
        m_clear = 0;
    endtask

    task automatic model_update(input logic fe, input logic btn, input logic col);
        bit rise;
        rise    = btn && (m_btnq == 0);
        m_clear = 0;
        case (m_mode)
            0: if (rise) begin
                m_mode = 1; m_ticks = 0; m_clear = 1;
            end
            1: if (fe) begin
                if (col) begin
                    m_mode = 2;
                    m_hold = 0;
                    if (m_score() > m_hi) m_hi = m_score();
                end else begin
                    m_ticks++;
                end
            end
            default: begin
                if (rise && m_hold == HOLD_FRAMES) begin
                    m_mode = 1; m_ticks = 0; m_clear = 1;
                end else if (fe && m_hold < HOLD_FRAMES) begin
                    m_hold++;
                end
            end
        endcase
        m_btnq = btn ? 1 : 0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("state",     int'(state),     m_mode);
        chk("run_en",    int'(run_en),    (m_mode == 1) ? 1 : 0);
        chk("obj_clear", int'(obj_clear), m_clear);
        chk("score",     int'(score),     m_score());
        chk("hi_score",  int'(hi_score),  m_hi);
        chk("speed",     int'(speed),     m_speed());
        chk("game_over", int'(game_over), (m_mode == 2) ? 1 : 0);
    endtask

    // Apply one cycle of inputs, advance the model, compare after the edge.
    task automatic step(input logic fe, input logic btn, input logic col, input bit full);
        frame_tick = fe;
        jump_btn   = btn;
        collision  = col;
        @(posedge clk);
        model_update(fe, btn, col);
        #1;
        if (full) chk_model();
    endtask

    typedef struct {
        logic       fe;
        logic       btn;
        logic       col;
        logic [1:0] st;
        int         sc;
        logic       clr;
    } vec_t;

    vec_t tbl [14];

    initial begin
        // Reset, press, glitch between ticks, first score point, collision,
        // and a press right after the collision that must be ignored.
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 2'b00, 0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 2'b01, 0, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 2'b01, 0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 2'b01, 0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 2'b01, 0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 2'b01, 0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 2'b01, 0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 2'b01, 0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 2'b01, 0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 2'b01, 1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 2'b01, 1, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 2'b10, 1, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 2'b10, 1, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 2'b10, 1, 1'b0};

        rst_n      = 1'b0;
        frame_tick = 1'b0;
        jump_btn   = 1'b0;
        collision  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", int'(state), 0);
        chk("reset_speed", int'(speed), SPEED_INIT);
        chk("reset_run_en", int'(run_en), 0);
        rst_n = 1'b1;

        // Table vectors
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].fe, tbl[i].btn, tbl[i].col, 1'b1);
            chk($sformatf("vec%0d_state", i), int'(state), int'(tbl[i].st));
            chk($sformatf("vec%0d_score", i), int'(score), tbl[i].sc);
            chk($sformatf("vec%0d_clear", i), int'(obj_clear), int'(tbl[i].clr));
        end
        chk("vec_hi", int'(hi_score), 1);

        // Hold-off: press after 29 ticks ignored, after 30 accepted.
        // One tick was already taken by the last vector.
        for (int i = 0; i < 28; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("press_at_29_state", int'(state), 2);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("press_at_30_state", int'(state), 1);
        chk("press_at_30_clear", int'(obj_clear), 1);
        chk("press_at_30_score", int'(score), 0);

        // 60 clean ticks with collision glitches between them, button held.
        for (int i = 0; i < 60; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b1);
            step(1'b1, 1'b1, 1'b0, 1'b1);
            chk("held_btn_no_clear", int'(obj_clear), 0);
        end
        chk("sixty_ticks_score", int'(score), 10);
        chk("sixty_ticks_speed", int'(speed), 4);
        chk("glitch_state", int'(state), 1);

        // Reach score 41 with the divider one tick from wrapping, then a
        // collision on the wrapping tick, button held across it.
        for (int i = 0; i < 186 + 5; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("wrap_hit_state", int'(state), 2);
        chk("wrap_hit_score", int'(score), 41);
        chk("wrap_hit_hi", int'(hi_score), 41);
        for (int i = 0; i < 35; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("held_across_hit", int'(state), 2);

        // Second run ending at 20 keeps the high score at 41.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 120; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        chk("run2_score", int'(score), 20);
        chk("run2_hi", int'(hi_score), 41);

        // Speed step at 99 -> 100, then run up to the score ceiling.
        for (int i = 0; i < HOLD_FRAMES; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("run3_state", int'(state), 1);
        for (int i = 0; i < 599; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("score_99", int'(score), 99);
        chk("speed_at_99", int'(speed), 4);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("score_100", int'(score), 100);
        chk("speed_at_100", int'(speed), 5);
        for (int i = 0; i < SCORE_MAX * SCORE_DIV - 600; i++)
            step(1'b1, 1'b0, 1'b0, (i % 500) == 0);
        chk_model();
        chk("score_ceiling", int'(score), 9999);
        chk("speed_ceiling", int'(speed), 12);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("score_stays_max", int'(score), 9999);
        chk("speed_stays_max", int'(speed), 12);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        chk("hi_max", int'(hi_score), 9999);

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            logic fe, btn, col;
            fe  = ($urandom_range(0, 2) == 0);
            btn = ($urandom_range(0, 7) == 0) ? ~jump_btn : jump_btn;
            col = ($urandom_range(0, 19) == 0);
            step(fe, btn, col, 1'b1);
        end

        // Fresh reset, run to 57, then reset asynchronously mid-cycle.
        step(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        step(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 57 * SCORE_DIV; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("pre_reset_score", int'(score), 57);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_state", int'(state), 0);
        chk("async_rst_run_en", int'(run_en), 0);
        chk("async_rst_score", int'(score), 0);
        chk("async_rst_hi", int'(hi_score), 0);
        chk("async_rst_speed", int'(speed), SPEED_INIT);
        chk("async_rst_game_over", int'(game_over), 0);
        chk("async_rst_clear", int'(obj_clear), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dino_game_controller.md
Name: dino_game_controller

Overview:
Top-level game sequencer for the dino runner. Owns the IDLE/RUNNING/GAME_OVER state machine, samples the combinational collision flag once per frame, and keeps the score, high score and scroll speed. Gates the obstacle scroller (run_en, speed) and clears obstacle positions at the start of every run (obj_clear).

Parameters:
SCORE_DIV, 6, frame ticks per score point while RUNNING
SCORE_MAX, 9999, score saturation value
SPEED_INIT, 4, scroll speed (pixels/frame) at run start
SPEED_MAX, 12, speed saturation value
SPEED_STEP, 100, score points per speed increment
HOLD_FRAMES, 30, frame ticks in GAME_OVER before a restart press is accepted

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse per video frame (at vsync start)
jump_btn  in  1  synchronised, debounced button level
collision  in  1  combinational hit flag from the collision detector
state  out  2  00 IDLE, 01 RUNNING, 10 GAME_OVER
run_en  out  1  high while RUNNING; obstacle scroller and dino physics advance only when high
obj_clear  out  1  one-cycle pulse: reset obstacle x positions and dino y
score  out  14  current score, binary
hi_score  out  14  best score since reset
speed  out  4  scroll speed for obstacle mover
game_over  out  1  high in GAME_OVER (drives overlay text)

Behaviour:
- One clock; reset is asynchronous and active-low. All registers reset asynchronously on rst_n low.
- Reset values: state=IDLE, run_en=0, obj_clear=0, score=0, hi_score=0, speed=SPEED_INIT, game_over=0. Internal counters and btn_q=0.
- Reset asserted mid-run: immediate return to IDLE. hi_score is lost.
- Edge detection: btn_q registers jump_btn. btn_rise = jump_btn & ~btn_q. Only rising edges start or restart a run. A held button never retriggers.
- IDLE: on btn_rise, at that same clock edge: state<=RUNNING, obj_clear<=1 for one cycle, score<=0, speed<=SPEED_INIT, frame divider<=0, step counter<=0.
- RUNNING:
  - run_en=1. Jumps while RUNNING are handled by the dino physics block; the controller ignores btn_rise here.
  - collision is evaluated only in cycles where frame_tick=1. Glitches between ticks are ignored.
  - On frame_tick with collision=1: state<=GAME_OVER, hold counter<=0, hi_score<=max(hi_score, score). No score or speed update occurs on that tick, so collision wins over increment.
  - On frame_tick with collision=0: frame divider increments. When it reaches SCORE_DIV-1 it wraps to 0 and score increments, saturating at SCORE_MAX.
  - Each score increment also advances the step counter. When the step counter reaches SPEED_STEP-1 it wraps and speed increments, saturating at SPEED_MAX.
  - Once score is at SCORE_MAX it stops changing and the step counter stops advancing.
- GAME_OVER:
  - run_en=0, game_over=1. score, speed and hi_score hold their values.
  - The hold counter increments on each frame_tick and saturates at HOLD_FRAMES.
  - btn_rise is ignored while hold counter < HOLD_FRAMES.
  - btn_rise with hold counter == HOLD_FRAMES triggers the same restart actions as in IDLE and transitions to RUNNING.
- Latency: run_en and state change on the clock edge that samples the triggering event. Outputs are registered, with no combinational path from inputs to outputs.
- obj_clear is never high for more than one cycle. It is always coincident with the first cycle of RUNNING.
- Illegal state encoding 11 recovers to IDLE on the next clock.

Test Plan:
- Reset, then jump_btn rise -> next edge state=01, obj_clear high exactly 1 cycle, speed=4, score=0. Holding jump_btn high for 10 cycles gives no second obj_clear.
- RUNNING, collision=0, 60 frame_ticks -> score=10, speed=4. Collision pulses placed between ticks -> no state change.
- Preload the step so score goes 99->100 -> speed 4->5 on the same edge. Force score to 9999 and apply 12 more ticks -> score remains 9999. Speed never exceeds 12.
- Collision and a score-wrap tick in the same cycle (score=41) -> GAME_OVER, score stays 41, hi_score=41. A second run ending at 20 -> hi_score stays 41.
- GAME_OVER: press at 29 frame_ticks -> stays in GAME_OVER. Press after 30 ticks -> RUNNING, score=0, obj_clear pulse. A button held across the collision does not restart.
- Assert rst_n low mid-RUNNING with score=57 -> outputs immediately reset values, state=IDLE, hi_score=0.
